uart_date_cmd_parser: RTL and testbench
=======================================

// Module: uart_date_cmd_parser
// PURPOSE
//  Parses date-set commands from the UART receive byte stream and presents a validated
//  binary day/month/year triple with a one-cycle load strobe to the calendar stage.
//  Sits between the UART RX byte engine and the calendar; it drives Less_uart/Middle_uart/Big_uart/uart_sign.
//  Frame format: 'D' Y Y M M D D <CR|LF>, with ASCII decimal digits and a two-digit year (2000+YY).
// PARAMETERS
//  HDR_BYTE       8'h44       frame header ('D')
//  TIMEOUT_CYCLES 50_000_000  max clk cycles between bytes of one frame before the frame is aborted
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  rx_data      in   8  received byte from UART RX
//  rx_valid     in   1  one-cycle strobe; rx_data valid this cycle (no backpressure)
//  Less_uart    out  7  day, binary 1..31
//  Middle_uart  out  7  month, binary 1..12
//  Big_uart     out  7  year, binary 0..99
//  uart_sign    out  1  one-cycle pulse: new date loaded on the three outputs
//  frame_err    out  1  one-cycle pulse: frame rejected (bad char, range, timeout)
// BEHAVIOUR
//  Reset values: Less_uart=3, Middle_uart=3, Big_uart=24, uart_sign=0, frame_err=0, state=IDLE, digit count=0, timer=0.
//  States: IDLE -> DIGITS (6 digits, idx 0..5) -> TERM -> IDLE.
//  IDLE: rx_valid with HDR_BYTE -> DIGITS idx=0 and clear the accumulators. Any other byte is ignored silently.
//  DIGITS: rx_valid with '0'..'9' -> store nibble, idx++; when idx 5 is taken -> TERM.
//    rx_valid with HDR_BYTE -> resync: restart at idx=0, no frame_err.
//    Any other byte -> frame_err pulse, go to IDLE.
//  TERM: rx_valid with 8'h0D or 8'h0A -> validate; any other byte (incl. header) -> frame_err, IDLE.
//  Conversion: each field = tens*10 + ones (tens*8 + tens*2 + ones); result width 7 bits.
//  Validation at the terminator:
//    month 1..12; day >= 1 and day <= days_in_month.
//    days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb is 29 if year%4==0, else 28.
//  Valid: outputs update and uart_sign=1 in the cycle after the terminator is accepted (latency 1).
//    Outputs then hold until the next valid frame.
//  Invalid: frame_err=1 in that same cycle; outputs are unchanged.
//  uart_sign and frame_err are never high in the same cycle; each is exactly 1 cycle wide.
//  Timeout: outside IDLE, the timer counts clk cycles since the last rx_valid and is cleared on each rx_valid.
//    Reaching TIMEOUT_CYCLES -> frame_err pulse, IDLE. In IDLE the timer is held at 0.
//  rx_valid in the same cycle as a timeout: the byte is processed and the timeout is discarded.
//  Reset asserted mid-frame: partial frame discarded, outputs return to reset values immediately (async).
// STRUCTURE
//  Shared package (calendar_pkg): HDR_BYTE default, ASCII_CR/ASCII_LF/ASCII_0/ASCII_9, parser state enum,
//    and a days_in_month(month, year) function, also reusable by the calendar.
//  One sub-module: dec2_to_bin (two 4-bit BCD digits in -> 7-bit binary out, purely combinational).
//  Instantiated three times; the FSM, timer and validation stay in this module.
// TESTING
//  1. Bytes "D240315\r" -> uart_sign one cycle after '\r'; Big=24, Middle=3, Less=15; frame_err stays 0.
//  2. "D230229\n" -> frame_err pulse, outputs unchanged; then "D240229\n" -> uart_sign, Less=29, Middle=2.
//  3. "D24131" then "5\r" (month 13), and "D2403A1\r" -> one frame_err each, no uart_sign.
//  4. "D24" then an idle gap of TIMEOUT_CYCLES (small value in sim, e.g. 100) -> frame_err at cycle 100, state IDLE.
//     A following "D991231\r" -> Big=99, Middle=12, Less=31.
//  5. "D24D240430\r" -> resync on the second 'D'; uart_sign with Middle=4, Less=30; no frame_err.
//  6. Assert reset after "D2403" -> outputs 3/3/24. Then "15\r" is ignored, with no pulses on either strobe.

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared calendar definitions: ASCII constants, parser state encoding and month-length lookup.
// Used by the UART date parser and reusable by the calendar stage.
package calendar_pkg;

    localparam logic [7:0] HDR_BYTE_DEF = 8'h44;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;

    localparam logic [6:0] RST_DAY   = 7'd3;
    localparam logic [6:0] RST_MONTH = 7'd3;
    localparam logic [6:0] RST_YEAR  = 7'd24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIGITS,
        ST_TERM
    } parser_state_t;

    // Year is the two-digit offset from 2000, so every multiple of 4 is a leap year.
    function automatic logic [4:0] days_in_month(input logic [6:0] month, input logic [6:0] year);
        case (month)
            7'd1, 7'd3, 7'd5, 7'd7, 7'd8, 7'd10, 7'd12: return 5'd31;
            7'd4, 7'd6, 7'd9, 7'd11:                    return 5'd30;
            7'd2:    return (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/dec2_to_bin.sv
// Two BCD digits to 7-bit binary (tens*10 + ones) using shifts and adds only.
module dec2_to_bin (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] bin
);

    assign bin = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};

endmodule

// File: rtl/uart_date_cmd_parser.sv
// Parses "D YYMMDD <CR|LF>" frames from the UART byte stream and loads a validated date.
//
// state     | meaning
// ST_IDLE   | waiting for header byte, timer held at 0
// ST_DIGITS | collecting six ASCII digits (idx 0..5)
// ST_TERM   | waiting for CR/LF, then validate and load
module uart_date_cmd_parser
    import calendar_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE       = HDR_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] Less_uart,
    output logic [6:0] Middle_uart,
    output logic [6:0] Big_uart,
    output logic       uart_sign,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    parser_state_t state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   digits_q, digits_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    day_d, month_d, year_d;
    logic          sign_d, err_d;

    logic [6:0] year_bin, month_bin, day_bin;
    logic       is_digit, is_term, is_hdr, date_ok, timeout;

    // Digit slot 0 is the year tens digit; slots follow arrival order.
    dec2_to_bin u_year  (.tens(digits_q[3:0]),   .ones(digits_q[7:4]),   .bin(year_bin));
    dec2_to_bin u_month (.tens(digits_q[11:8]),  .ones(digits_q[15:12]), .bin(month_bin));
    dec2_to_bin u_day   (.tens(digits_q[19:16]), .ones(digits_q[23:20]), .bin(day_bin));

    assign is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
    assign is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    assign is_hdr   = (rx_data == HDR_BYTE);
    assign date_ok  = (month_bin >= 7'd1) && (month_bin <= 7'd12) && (day_bin != 7'd0)
                   && (day_bin <= {2'b00, days_in_month(month_bin, year_bin)});
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout  = (state_q != ST_IDLE) && !rx_valid && (timer_q == TIMER_LAST);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        digits_d = digits_q;
        day_d    = Less_uart;
        month_d  = Middle_uart;
        year_d   = Big_uart;
        sign_d   = 1'b0;
        err_d    = 1'b0;
        timer_d  = (state_q == ST_IDLE || rx_valid) ? '0 : timer_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && is_hdr) begin
                    state_d  = ST_DIGITS;
                    idx_d    = 3'd0;
                    digits_d = '0;
                end
            end
            ST_DIGITS: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        digits_d[{idx_q, 2'b00} +: 4] = rx_data[3:0];
                        if (idx_q == 3'd5) state_d = ST_TERM;
                        else               idx_d   = idx_q + 3'd1;
                    end else if (is_hdr) begin
                        idx_d    = 3'd0;
                        digits_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_TERM: begin
                if (rx_valid) begin
                    state_d = ST_IDLE;
                    if (is_term && date_ok) begin
                        day_d   = day_bin;
                        month_d = month_bin;
                        year_d  = year_bin;
                        sign_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            digits_q    <= '0;
            timer_q     <= '0;
            Less_uart   <= RST_DAY;
            Middle_uart <= RST_MONTH;
            Big_uart    <= RST_YEAR;
            uart_sign   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            digits_q    <= digits_d;
            timer_q     <= timer_d;
            Less_uart   <= day_d;
            Middle_uart <= month_d;
            Big_uart    <= year_d;
            uart_sign   <= sign_d;
            frame_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_date_cmd_parser.sv
// Self-checking bench for uart_date_cmd_parser: directed vectors, timing corners and random frames.
module tb_uart_date_cmd_parser;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [6:0] Less_uart, Middle_uart, Big_uart;
    logic       uart_sign, frame_err;

    always #5 clk = ~clk;

    uart_date_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .Less_uart(Less_uart), .Middle_uart(Middle_uart), .Big_uart(Big_uart),
        .uart_sign(uart_sign), .frame_err(frame_err)
    );

    int checks = 0;
    int failures = 0;
    int sign_cnt = 0;
    int err_cnt = 0;

    // Reference model: frame collected as a list of digit values, date checked arithmetically.
    bit m_in = 0;
    int m_buf[$];
    int m_less = 3, m_mid = 3, m_big = 24;
    int month_len[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    typedef struct {
        string s;
        int    signs;
        int    errs;
        int    less;
        int    mid;
        int    big;
    } vec_t;
    vec_t vecs[$];

    function automatic bit date_ok(input int d, input int mo, input int y);
        int lim;
        if (mo < 1 || mo > 12) return 0;
        lim = month_len[mo];
        if (mo == 2 && y % 4 == 0) lim = 29;
        return (d >= 1 && d <= lim);
    endfunction

    task automatic model_byte(input logic [7:0] b, output bit s, output bit e);
        int y, mo, d;
        s = 0;
        e = 0;
        if (!m_in) begin
            if (b == "D") begin
                m_in = 1;
                m_buf.delete();
            end
        end else if (m_buf.size() < 6) begin
            if (b >= "0" && b <= "9") m_buf.push_back(int'(b) - 48);
            else if (b == "D") m_buf.delete();
            else begin
                e = 1;
                m_in = 0;
            end
        end else begin
            m_in = 0;
            y  = m_buf[0] * 10 + m_buf[1];
            mo = m_buf[2] * 10 + m_buf[3];
            d  = m_buf[4] * 10 + m_buf[5];
            if ((b == 8'h0D || b == 8'h0A) && date_ok(d, mo, y)) begin
                s = 1;
                m_less = d;
                m_mid = mo;
                m_big = y;
            end else begin
                e = 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample(input bit es, input bit ee, input string tag);
        chk({tag, " uart_sign"}, int'(uart_sign), int'(es));
        chk({tag, " frame_err"}, int'(frame_err), int'(ee));
        chk({tag, " Less_uart"}, int'(Less_uart), m_less);
        chk({tag, " Middle_uart"}, int'(Middle_uart), m_mid);
        chk({tag, " Big_uart"}, int'(Big_uart), m_big);
        if (uart_sign) sign_cnt++;
        if (frame_err) err_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit es, ee;
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        model_byte(b, es, ee);
        sample(es, ee, "byte");
        repeat (gap) begin
            @(posedge clk);
            #1;
            sample(1'b0, 1'b0, "idle");
        end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]), gap);
    endtask

    function automatic void add_vec(input string s, input int sg, input int er,
                                    input int l, input int m, input int b);
        vec_t v;
        v.s = s; v.signs = sg; v.errs = er; v.less = l; v.mid = m; v.big = b;
        vecs.push_back(v);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0, at;

        add_vec("D240315\r",    1, 0, 15,  3, 24);
        add_vec("D230229\n",    0, 1, 15,  3, 24);
        add_vec("D240229\n",    1, 0, 29,  2, 24);
        add_vec("D241315\r",    0, 1, 29,  2, 24);
        add_vec("D2403A1\r",    0, 1, 29,  2, 24);
        add_vec("D24D240430\r", 1, 0, 30,  4, 24);
        add_vec("D240431\r",    0, 1, 30,  4, 24);
        add_vec("D000229\r",    1, 0, 29,  2,  0);
        add_vec("D241200\n",    0, 1, 29,  2,  0);
        add_vec("xq\nD251231\r",1, 0, 31, 12, 25);
        add_vec("D2402D\r",     0, 1, 31, 12, 25);
        add_vec("D2401011",     0, 1, 31, 12, 25);
        add_vec("D230229D\r",   0, 1, 31, 12, 25);
        add_vec("D240230\r",    0, 1, 31, 12, 25);
        add_vec("D250228\r",    1, 0, 28,  2, 25);

        repeat (3) @(posedge clk);
        #1;
        sample(1'b0, 1'b0, "reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            s0 = sign_cnt;
            e0 = err_cnt;
            send_str(vecs[i].s, 1);
            chk($sformatf("vec%0d signs", i), sign_cnt - s0, vecs[i].signs);
            chk($sformatf("vec%0d errs", i), err_cnt - e0, vecs[i].errs);
            chk($sformatf("vec%0d day", i), int'(Less_uart), vecs[i].less);
            chk($sformatf("vec%0d month", i), int'(Middle_uart), vecs[i].mid);
            chk($sformatf("vec%0d year", i), int'(Big_uart), vecs[i].big);
        end

        // Byte arriving exactly in the expiry cycle keeps the frame alive.
        send_byte("D", 1);
        send_byte("2", 1);
        send_byte("4", T - 1);
        s0 = sign_cnt;
        send_str("0315\r", 1);
        chk("gap_boundary sign", sign_cnt - s0, 1);
        chk("gap_boundary day", int'(Less_uart), 15);

        // Idle gap after a partial frame aborts it after T cycles.
        send_str("D24", 0);
        at = 0;
        for (int i = 1; i <= T + 3; i++) begin
            @(posedge clk);
            #1;
            if (frame_err && at == 0) at = i;
            if (i == T) begin
                m_in = 0;
                sample(1'b0, 1'b1, "timeout");
            end else begin
                sample(1'b0, 1'b0, "timeout_wait");
            end
        end
        chk("timeout cycle", at, T);
        s0 = sign_cnt;
        send_str("D991231\r", 1);
        chk("after_timeout sign", sign_cnt - s0, 1);
        chk("after_timeout year", int'(Big_uart), 99);
        chk("after_timeout month", int'(Middle_uart), 12);
        chk("after_timeout day", int'(Less_uart), 31);

        // Reset mid-frame: outputs return immediately, rest of the frame is ignored.
        send_str("D2403", 1);
        #3;
        reset = 1'b1;
        #1;
        m_in = 0; m_less = 3; m_mid = 3; m_big = 24;
        sample(1'b0, 1'b0, "async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        s0 = sign_cnt;
        e0 = err_cnt;
        send_str("15\r", 1);
        chk("post_reset signs", sign_cnt - s0, 0);
        chk("post_reset errs", err_cnt - e0, 0);
        chk("post_reset year", int'(Big_uart), 24);

        for (int n = 0; n < 200; n++) begin
            int yy, mm, dd;
            logic [7:0] fr [8];
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(32, 126)), $urandom_range(0, 2));
            yy = $urandom_range(0, 99);
            mm = $urandom_range(0, 13);
            dd = $urandom_range(0, 32);
            fr[0] = "D";
            fr[1] = 8'(48 + yy / 10);
            fr[2] = 8'(48 + yy % 10);
            fr[3] = 8'(48 + mm / 10);
            fr[4] = 8'(48 + mm % 10);
            fr[5] = 8'(48 + dd / 10);
            fr[6] = 8'(48 + dd % 10);
            case ($urandom_range(0, 5))
                0, 1:    fr[7] = 8'h0D;
                2, 3:    fr[7] = 8'h0A;
                4:       fr[7] = "D";
                default: fr[7] = "Z";
            endcase
            if ($urandom_range(0, 7) == 0) fr[$urandom_range(1, 7)] = 8'($urandom_range(32, 126));
            for (int k = 0; k < 8; k++) send_byte(fr[k], $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
